full_stage_ctrl_gen: RTL

- Parametrised next-generation controller for a fully-connected stage's tap, bias and error-output paths.
- Arbitrates the tap read address between the normal and error-update phases, and pipelines the read address into a write-back address with configurable latency.
- Counts write-backs, and drives the error (zerror) output through a 2-entry valid/ready buffer instead of a fire-and-forget valid.
- Sits between the stage sequencer and the tap/bias memories plus the stage datapath.

---
 rtl/full_stage_ctrl_gen_pkg.sv | 24 ++
 rtl/full_stage_ctrl_gen_if.sv | 33 +++
 rtl/full_ctrl_skid_fifo.sv | 57 +++++
 rtl/full_stage_ctrl_gen.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/full_stage_ctrl_gen_pkg.sv
// rtl/full_stage_ctrl_gen_pkg.sv - shared types and defaults for the fully-connected stage controller
package full_stage_ctrl_gen_pkg;

  localparam int FC_DW        = 32;
  localparam int FC_TAP_AW    = 5;
  localparam int FC_NTAPS     = 6;
  localparam int ERR_BASE_DEF = 12;

  typedef logic [FC_DW-1:0] float_24_8;

  // Tap-memory side bundle as seen by the stage datapath
  typedef struct packed {
    logic [FC_TAP_AW-1:0]         rd_addr;
    logic                         rd_vld;
    logic [FC_TAP_AW-1:0]         wr_addr;
    logic                         wr_vld;
    logic                         sub_vld;
    logic [FC_TAP_AW-1:0]         sub_addr;
    logic [FC_NTAPS*FC_DW-1:0]    sub_data;
    logic                         inter;
    logic                         inter_first;
  } tap_if_t;

endpackage

// File: rtl/full_stage_ctrl_gen_if.sv
// rtl/full_stage_ctrl_gen_if.sv - tap/bias memory control and zerror stream bundle
interface full_stage_ctrl_gen_if #(
  parameter int TAP_AW = 5,
  parameter int DW     = 32
);

  logic [TAP_AW-1:0] tap_rd_addr;
  logic              tap_rd_vld;
  logic [TAP_AW-1:0] tap_wr_addr;
  logic              tap_wr_vld;
  logic              tap_sub_vld;
  logic              bias_wr_vld;
  logic              tap_rd_stall;
  logic [DW-1:0]     zerror_data;
  logic              zerror_vld;
  logic              zerror_rdy;
  logic              zerror_ovf;

  modport master (
    output tap_rd_addr, tap_rd_vld, tap_wr_addr, tap_wr_vld, tap_sub_vld,
    output bias_wr_vld, tap_rd_stall,
    output zerror_data, zerror_vld, zerror_ovf,
    input  zerror_rdy
  );

  modport slave (
    input  tap_rd_addr, tap_rd_vld, tap_wr_addr, tap_wr_vld, tap_sub_vld,
    input  bias_wr_vld, tap_rd_stall,
    input  zerror_data, zerror_vld, zerror_ovf,
    output zerror_rdy
  );

endinterface

// File: rtl/full_ctrl_skid_fifo.sv
// rtl/full_ctrl_skid_fifo.sv - 2-entry first-word-fall-through FIFO with sticky overflow flag
module full_ctrl_skid_fifo #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          ovf
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    cnt;
  logic          full;
  logic          pop;
  logic          push_ok;

  assign full     = (cnt == 2'd2);
  assign m_tvalid = (cnt != 2'd0);
  assign m_tdata  = mem[rd_ptr];
  assign pop      = m_tvalid & m_tready;
  // A pop in the same cycle frees the slot the push lands in
  assign push_ok  = s_tvalid & (~full | pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= s_tdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      if (s_tvalid && full && !pop) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/full_stage_ctrl_gen.sv
// rtl/full_stage_ctrl_gen.sv - tap/bias/zerror controller for a fully-connected stage
// Optional read/write-back hazard detect under FULL_CTRL_HAZARD_EN.
module full_stage_ctrl_gen
  import full_stage_ctrl_gen_pkg::*;
#(
  parameter int NTAPS    = FC_NTAPS,
  parameter int DW       = FC_DW,
  parameter int TAP_AW   = FC_TAP_AW,
  parameter int PH_W     = 2,
  parameter int ERR_BASE = ERR_BASE_DEF,
  parameter int UPD_LAT  = 5,
  parameter int ERR_LAT  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active_normal,
  input  logic              active_start_d,
  input  logic [TAP_AW-1:0] tap_address,
  input  logic              error_update_first,
  input  logic              error_update_latch,
  input  logic              error_tap_update_out,
  input  logic [PH_W-1:0]   error_phase,
  input  logic [PH_W-1:0]   error_phase_read,
  input  logic              error_valid,
  input  logic [TAP_AW-1:0] error_tap_length,
  input  logic              tap_enable,
  input  logic              bias_enable,
  input  logic [TAP_AW-1:0] bias_wr_address,
  input  logic [DW-1:0]     data_out_pre,
  output logic              wb_done,
  full_stage_ctrl_gen_if.master bus
);

  localparam logic [TAP_AW-1:0] ERR_BASE_A = TAP_AW'(ERR_BASE);

  if (UPD_LAT < 2 || ERR_LAT < 3 || NTAPS < 1) begin : g_param_check
    $error("full_stage_ctrl_gen: UPD_LAT>=2, ERR_LAT>=3, NTAPS>=1 required");
  end

  logic [TAP_AW-1:0] rd_addr;
  logic              wb_req;
  logic [UPD_LAT:1]  pipe_vld;
  logic [TAP_AW-1:0] pipe_addr [1:UPD_LAT];
  logic [UPD_LAT:1]  upd_sr;
  logic              upd_d;
  logic              wb_wr;
  logic [TAP_AW-1:0] wb_cnt;
  logic              cnt_last;
  logic [ERR_LAT:1]  err_sr;
  logic [2:1]        start_sr;
  logic              z_push;
  logic [DW-1:0]     z_tdata;
  logic              z_tvalid;
  logic              z_ovf;

  // Read address arbitration between normal and error-update phases
  assign rd_addr = error_update_first ? ERR_BASE_A + TAP_AW'(error_phase_read) : tap_address;
  assign wb_req  = error_update_latch & ~error_update_first;

  assign bus.tap_rd_addr = rd_addr;
  assign bus.tap_rd_vld  = active_normal;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe_vld <= '0;
      upd_sr   <= '0;
      for (int k = 1; k <= UPD_LAT; k++) begin
        pipe_addr[k] <= '0;
      end
    end else begin
      pipe_vld     <= {pipe_vld[UPD_LAT-1:1], wb_req};
      upd_sr       <= {upd_sr[UPD_LAT-1:1], error_tap_update_out};
      pipe_addr[1] <= rd_addr;
      for (int k = 2; k <= UPD_LAT; k++) begin
        pipe_addr[k] <= pipe_addr[k-1];
      end
    end
  end

  assign upd_d = upd_sr[UPD_LAT];
  assign wb_wr = pipe_vld[UPD_LAT] & tap_enable & ~upd_d;

  // A write-back owns the write port; error accumulates only use it when idle
  assign bus.tap_wr_addr = pipe_vld[UPD_LAT] ? pipe_addr[UPD_LAT]
                                             : ERR_BASE_A + TAP_AW'(error_phase);
  assign bus.tap_wr_vld  = error_valid | wb_wr;
  assign bus.tap_sub_vld = ~pipe_vld[UPD_LAT] & error_valid;
  assign bus.bias_wr_vld = bias_enable & pipe_vld[UPD_LAT-1];

  assign cnt_last = (error_tap_length != '0) && (wb_cnt == error_tap_length - TAP_AW'(1));
  assign wb_done  = wb_wr & cnt_last & ~active_start_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_cnt <= '0;
    end else if (active_start_d) begin
      wb_cnt <= '0;
    end else if (wb_wr) begin
      wb_cnt <= cnt_last ? '0 : wb_cnt + TAP_AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_sr   <= '0;
      start_sr <= '0;
    end else begin
      err_sr   <= {err_sr[ERR_LAT-1:1], error_tap_update_out};
      start_sr <= {start_sr[1], active_start_d};
    end
  end

  assign z_push = err_sr[ERR_LAT] & ~start_sr[2];

  full_ctrl_skid_fifo #(
    .DW (DW)
  ) u_zerror_fifo (
    .clk      (clk),
    .reset    (reset),
    .s_tdata  (data_out_pre),
    .s_tvalid (z_push),
    .m_tdata  (z_tdata),
    .m_tvalid (z_tvalid),
    .m_tready (bus.zerror_rdy),
    .ovf      (z_ovf)
  );

  assign bus.zerror_data = z_tdata;
  assign bus.zerror_vld  = z_tvalid;
  assign bus.zerror_ovf  = z_ovf;

`ifdef FULL_CTRL_HAZARD_EN
  logic hazard_hit;

  // Any in-flight write-back to the address being read is a hazard
  always_comb begin
    hazard_hit = 1'b0;
    for (int k = 1; k <= UPD_LAT; k++) begin
      if (pipe_vld[k] && (pipe_addr[k] == rd_addr)) begin
        hazard_hit = 1'b1;
      end
    end
  end

  assign bus.tap_rd_stall = active_normal & hazard_hit;
`else
  assign bus.tap_rd_stall = 1'b0;
`endif

  // Bias writes reuse the pipe timing; the address comes straight from the sequencer
  logic unused_bias_addr;
  assign unused_bias_addr = ^bias_wr_address;

endmodule
